div8x4: RTL and testbench
=========================

DIV8X4 -- requirements
Module: div8x4

Interface
REQ-001 The block SHALL have the port `clk`, an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `rst`, an input, 1 bit wide: a synchronous, active-high reset.
REQ-003 The block SHALL have the port `St`, an input, 1 bit wide: start request, sampled on a rising edge of `clk`.
REQ-004 The block SHALL have the port `Dividend`, an input, 8 bits wide: unsigned dividend, captured when `St` is accepted.
REQ-005 The block SHALL have the port `Divisor`, an input, 4 bits wide: unsigned divisor, captured when `St` is accepted.
REQ-006 The block SHALL have the port `Quot`, an output, 4 bits wide: registered unsigned quotient.
REQ-007 The block SHALL have the port `Rem`, an output, 4 bits wide: registered unsigned remainder.
REQ-008 The block SHALL have the port `V`, an output, 1 bit wide: registered overflow flag (quotient does not fit in 4 bits, or divide-by-zero).
REQ-009 The block SHALL have the port `done`, an output, 1 bit wide: registered completion flag.

Function
REQ-010 The block SHALL perform restoring shift-subtract division using a 9-bit working register ACC[8:0] and a 2-bit iteration counter.
REQ-011 The FSM SHALL have exactly these states: IDLE, CHK, SHIFT, SUB.
REQ-012 In IDLE, an `St`=1 sampled at an edge SHALL capture `Dividend`/`Divisor`, clear `done`, `V`, `Quot` and `Rem` to 0, and move the FSM to CHK.
REQ-013 `St` SHALL be ignored in CHK, SHIFT and SUB, and the captured operands SHALL NOT change until the next acceptance.
REQ-014 CHK: if `Divisor`==0 or `Dividend`[7:4] >= `Divisor`, the block SHALL set `V`=1, `done`=1, `Quot`=0 and `Rem`=0, then return to IDLE.
REQ-015 CHK: otherwise the block SHALL load ACC={1'b0,`Dividend`}, clear the counter, and go to SHIFT.
REQ-016 SHIFT: the block SHALL set ACC = ACC shifted left by one with a 0 inserted at bit 0, then go to SUB.
REQ-017 SUB: if ACC[8:4] >= {1'b0,`Divisor`}, the block SHALL set ACC[8:4] = ACC[8:4] - `Divisor` and ACC[0]=1; otherwise ACC SHALL be unchanged.
REQ-018 SUB with counter<3: the counter SHALL increment by 1, and the FSM SHALL go to SHIFT.
REQ-019 SUB with counter==3: the block SHALL write `Quot`=ACC[3:0] and `Rem`=ACC[7:4] (post-subtract values), set `done`=1 and `V`=0, and return to IDLE.
REQ-020 Normal latency SHALL be: outputs and `done` valid after the 9th rising edge following the `St`-accept edge (1 CHK + 8 SHIFT/SUB).
REQ-021 Overflow latency SHALL be: `V`/`done` valid after the 1st edge following the accept edge.
REQ-022 `done`, `V`, `Quot` and `Rem` SHALL hold their values in IDLE until the next `St` acceptance or `rst`.
REQ-023 If `St` is held high continuously, the block SHALL start a new division on every IDLE cycle, so `done` goes high for exactly one cycle per operation.
REQ-024 Arithmetic: the compare and subtract SHALL be 5-bit unsigned, and ACC[8] SHALL be 0 after every SUB.

Reset
REQ-025 When `rst`=1 at a rising edge, the FSM SHALL go to IDLE, and ACC, the counter, `Quot`, `Rem`, `V` and `done` SHALL all go to 0.
REQ-026 `rst` SHALL take priority over `St` in the same cycle.
REQ-027 A reset mid-operation SHALL abort the division with no partial result appearing on the outputs.

Verification
REQ-028 `Dividend`=135, `Divisor`=13, `St` pulse -> after 9 edges: `Quot`=10, `Rem`=5, `V`=0, `done`=1.
REQ-029 `Dividend`=239, `Divisor`=15 -> `Quot`=15, `Rem`=14, `V`=0 (largest non-overflow quotient).
REQ-030 `Dividend`=200, `Divisor`=7; then `Dividend`=50, `Divisor`=0 -> after 1 edge each: `V`=1, `done`=1, `Quot`=0, `Rem`=0.
REQ-031 `Dividend`=0, `Divisor`=5 -> `Quot`=0, `Rem`=0, `V`=0; then `Dividend`=3, `Divisor`=9 -> `Quot`=0, `Rem`=3.
REQ-032 Start 135/13, pulse `St` with 255/1 at edge 4 -> ignored, result 10 r 5; start 135/13 again, assert `rst` at edge 5 -> all outputs 0, IDLE, a new start then works.
REQ-033 Hold `St` high with 100/11 (in-range divisors) -> `done` pulses one cycle every 10 edges with `Quot`=9, `Rem`=1; exhaustive sweep of all 4096 operand pairs -> results match the integer /, % reference model, with `V` per REQ-014.

Source files
------------

// File: rtl/div8x4.sv
// div8x4: 8-bit by 4-bit unsigned restoring divider with a 4-bit quotient.
// One check cycle, then four shift/subtract iterations. The divisor must exceed
// the dividend's upper nibble. If it does not, or the divisor is zero, the
// division overflows and the block flags it.
module div8x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       St,
  input  logic [7:0] Dividend,
  input  logic [3:0] Divisor,
  output logic [3:0] Quot,
  output logic [3:0] Rem,
  output logic       V,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StChk, StShift, StSub} state_e;

  state_e     state_q, state_d;
  logic [8:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       v_q, v_d;
  logic       done_q, done_d;

  logic [4:0] acc_hi;
  logic [4:0] diff;
  logic       ge;
  logic       ovf;

  // 5-bit compare/subtract of the partial remainder and the overflow test.
  always_comb begin
    acc_hi = acc_q[8:4];
    ge     = (acc_hi >= {1'b0, dvs_q});
    diff   = acc_hi - {1'b0, dvs_q};
    ovf    = (dvs_q == 4'd0) || (dvd_q[7:4] >= dvs_q);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    v_d     = v_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle: begin
        if (St) begin
          dvd_d   = Dividend;
          dvs_d   = Divisor;
          quot_d  = 4'd0;
          rem_d   = 4'd0;
          v_d     = 1'b0;
          done_d  = 1'b0;
          state_d = StChk;
        end
      end
      StChk: begin
        if (ovf) begin
          v_d     = 1'b1;
          done_d  = 1'b1;
          quot_d  = 4'd0;
          rem_d   = 4'd0;
          state_d = StIdle;
        end else begin
          acc_d   = {1'b0, dvd_q};
          cnt_d   = 2'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d   = {acc_q[7:0], 1'b0};
        state_d = StSub;
      end
      StSub: begin
        // The quotient bit lands in acc[0], which SHIFT just cleared.
        if (ge) begin
          acc_d = {diff, acc_q[3:1], 1'b1};
        end
        if (cnt_q != 2'd3) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = StShift;
        end else begin
          // Results come from the post-subtract value.
          quot_d  = acc_d[3:0];
          rem_d   = acc_d[7:4];
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= 9'd0;
      cnt_q   <= 2'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      quot_q  <= 4'd0;
      rem_q   <= 4'd0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign Quot = quot_q;
  assign Rem  = rem_q;
  assign V    = v_q;
  assign done = done_q;

endmodule

// File: tb/tb_div8x4.sv
// Bench for div8x4: a cycle-level behavioural model built on integer / and %,
// compared with the DUT every cycle. Literal checks pin known results.
module tb_div8x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       St;
  logic [7:0] Dividend;
  logic [3:0] Divisor;
  logic [3:0] Quot;
  logic [3:0] Rem;
  logic       V;
  logic       done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  div8x4 dut (
    .clk      (clk),
    .rst      (rst),
    .St       (St),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quot     (Quot),
    .Rem      (Rem),
    .V        (V),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit overflows(input int a, input int b);
    if (b == 0) return 1'b1;
    return (a / b) > 15;
  endfunction

  // Reference model: results appear 9 edges after acceptance (1 on overflow).
  int         m_busy = 0;
  int         m_a = 0;
  int         m_b = 0;
  logic [3:0] m_q = '0;
  logic [3:0] m_r = '0;
  logic       m_v = 1'b0;
  logic       m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_v    <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy == 0) begin
      if (St) begin
        m_a    <= int'(Dividend);
        m_b    <= int'(Divisor);
        m_q    <= '0;
        m_r    <= '0;
        m_v    <= 1'b0;
        m_done <= 1'b0;
        m_busy <= overflows(int'(Dividend), int'(Divisor)) ? 1 : 9;
      end
    end else begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_done <= 1'b1;
        if (overflows(m_a, m_b)) begin
          m_v <= 1'b1;
          m_q <= '0;
          m_r <= '0;
        end else begin
          m_v <= 1'b0;
          m_q <= 4'(m_a / m_b);
          m_r <= 4'(m_a % m_b);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle {done,V,Quot,Rem}", {6'd0, done, V, Quot, Rem},
            {6'd0, m_done, m_v, m_q, m_r});
    end
  end

  task automatic start(input logic [7:0] a, input logic [3:0] b);
    Dividend = a;
    Divisor  = b;
    St       = 1'b1;
    @(posedge clk);
    #2;
    St = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic expect_res(input string name, input int lat, input int exp_lat,
                            input logic [3:0] q, input logic [3:0] r, input logic v);
    check({name, " latency"}, 16'(lat), 16'(exp_lat));
    check({name, " Quot"}, {12'd0, Quot}, {12'd0, q});
    check({name, " Rem"}, {12'd0, Rem}, {12'd0, r});
    check({name, " V"}, {15'd0, V}, {15'd0, v});
  endtask

  initial begin
    int lat;
    int pulses;
    rst      = 1'b1;
    St       = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    check("reset outputs", {6'd0, done, V, Quot, Rem}, 16'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    start(8'd135, 4'd13); wait_done(lat); expect_res("135/13", lat, 9, 4'd10, 4'd5, 1'b0);
    start(8'd239, 4'd15); wait_done(lat); expect_res("239/15", lat, 9, 4'd15, 4'd14, 1'b0);
    start(8'd200, 4'd7);  wait_done(lat); expect_res("200/7", lat, 1, 4'd0, 4'd0, 1'b1);
    start(8'd50, 4'd0);   wait_done(lat); expect_res("50/0", lat, 1, 4'd0, 4'd0, 1'b1);
    start(8'd0, 4'd5);    wait_done(lat); expect_res("0/5", lat, 9, 4'd0, 4'd0, 1'b0);
    start(8'd3, 4'd9);    wait_done(lat); expect_res("3/9", lat, 9, 4'd0, 4'd3, 1'b0);

    // A start pulse mid-operation must be ignored.
    start(8'd135, 4'd13);
    repeat (3) @(posedge clk);
    #2;
    Dividend = 8'd255; Divisor = 4'd1; St = 1'b1;
    @(posedge clk);
    #2;
    St = 1'b0;
    wait_done(lat);
    expect_res("ignored St", lat, 5, 4'd10, 4'd5, 1'b0);

    // Reset mid-operation aborts without producing a result.
    start(8'd135, 4'd13);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    check("after rst", {6'd0, done, V, Quot, Rem}, 16'd0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("no result after rst", 16'(pulses), 16'd0);
    #1;
    start(8'd135, 4'd13); wait_done(lat); expect_res("restart", lat, 9, 4'd10, 4'd5, 1'b0);

    // St held high: one done pulse every 10 edges.
    Dividend = 8'd100; Divisor = 4'd11; St = 1'b1;
    pulses = 0;
    @(posedge clk);
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        check("held St result", {8'd0, Quot, Rem}, {8'd0, 4'd9, 4'd1});
      end
    end
    St = 1'b0;
    check("held St pulses", 16'(pulses), 16'd3);
    repeat (12) @(posedge clk);
    #2;

    // Exhaustive sweep; the model comparison covers every cycle.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        start(8'(a), 4'(b));
        wait_done(lat);
        if (lat == 0) check("sweep timeout", 16'(lat), 16'd1);
      end
    end

    // Random stimulus with stray starts and occasional resets.
    repeat (3000) begin
      @(posedge clk);
      #2;
      St       = ($urandom % 4) == 0;
      Dividend = 8'($urandom);
      Divisor  = 4'($urandom);
      rst      = ($urandom % 64) == 0;
    end
    rst = 1'b0;
    St  = 1'b0;
    repeat (12) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
